// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package booth_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 6;

   // Shift-control codes used across the multiplication unit's datapath.
   typedef enum logic [1:0] {
      SH_NOP   = 2'b00,
      SH_RIGHT = 2'b01,
      SH_LEFT  = 2'b10,
      SH_ZERO  = 2'b11
   } shift_e;

   typedef enum logic [1:0] {
      BOOTH_NOP = 2'b00,
      BOOTH_ADD = 2'b01,
      BOOTH_SUB = 2'b10
   } booth_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Radix-2 Booth recoding of the pair {Q[0], q_1}.
   function automatic booth_op_e booth_decode(input logic q0, input logic q1);
      booth_op_e op;
      unique case ({q0, q1})
         2'b01:   op = BOOTH_ADD;
         2'b10:   op = BOOTH_SUB;
         default: op = BOOTH_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand and product valid/ready handshake bundle for booth_mult_seq.
interface booth_mult_seq_if
   import booth_pkg::*;
#(
   parameter int unsigned W = WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     multiplicand;
   logic [W-1:0]     multiplier;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   product;

   // Producer/consumer side (drives operands, accepts the product).
   modport master (
      output in_valid, multiplicand, multiplier, out_ready,
      input  in_ready, out_valid, product
   );

   // Multiplier side.
   modport slave (
      input  in_valid, multiplicand, multiplier, out_ready,
      output in_ready, out_valid, product
   );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M into the guarded
// accumulator followed by an arithmetic right shift of {A,Q,q_1}.
module booth_step
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   a_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic             q1_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH:0]   a_o,
   output logic [WIDTH-1:0] q_o,
   output logic             q1_o
);

   booth_op_e       op;
   logic [WIDTH:0]  m_ext;
   logic [WIDTH:0]  addend;
   logic            cin;
   logic [WIDTH:0]  sum;

   // Add, subtract (as ~M + 1) or pass, then shift right arithmetically.
   always_comb begin
      op     = booth_decode(q_i[0], q1_i);
      m_ext  = {m_i[WIDTH-1], m_i};
      addend = '0;
      cin    = 1'b0;
      unique case (op)
         BOOTH_ADD: begin
            addend = m_ext;
            cin    = 1'b0;
         end
         BOOTH_SUB: begin
            addend = ~m_ext;
            cin    = 1'b1;
         end
         default: begin
            addend = '0;
            cin    = 1'b0;
         end
      endcase
      sum  = a_i + addend + {{WIDTH{1'b0}}, cin};
      a_o  = {sum[WIDTH], sum[WIDTH:1]};
      q_o  = {sum[0], q_i[WIDTH-1:1]};
      q1_o = q_i[0];
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier, signed WIDTHxWIDTH -> 2*WIDTH,
// one step per clock, valid/ready on both operand and product sides.
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   booth_mult_seq_if.slave   bus
);

   state_e                 state_q, state_d;
   logic [WIDTH:0]         a_q, a_d;
   logic [WIDTH-1:0]       q_q, q_d;
   logic                   q1_q, q1_d;
   logic [WIDTH-1:0]       m_q, m_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [2*WIDTH-1:0]     prod_q, prod_d;

   logic [WIDTH:0]         step_a;
   logic [WIDTH-1:0]       step_q;
   logic                   step_q1;
   logic                   last_step;

   booth_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .a_i  (a_q),
      .q_i  (q_q),
      .q1_i (q1_q),
      .m_i  (m_q),
      .a_o  (step_a),
      .q_o  (step_q),
      .q1_o (step_q1)
   );

   assign last_step = (cnt_q == CNT_W'(1));

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: accept, count out the steps, wait for the consumer.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.in_valid)  state_d = RUN;
         RUN:     if (last_step)     state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // FSM outputs: handshake flags are pure functions of the state.
   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         q_q    <= '0;
         q1_q   <= 1'b0;
         m_q    <= '0;
         cnt_q  <= '0;
         prod_q <= '0;
      end else begin
         a_q    <= a_d;
         q_q    <= q_d;
         q1_q   <= q1_d;
         m_q    <= m_d;
         cnt_q  <= cnt_d;
         prod_q <= prod_d;
      end
   end

   // Datapath next-state. The product is captured from the final step's
   // result so it stays put once a new operation reloads A and Q.
   always_comb begin
      a_d    = a_q;
      q_d    = q_q;
      q1_d   = q1_q;
      m_d    = m_q;
      cnt_d  = cnt_q;
      prod_d = prod_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               m_d   = bus.multiplicand;
               q_d   = bus.multiplier;
               a_d   = '0;
               q1_d  = 1'b0;
               cnt_d = CNT_W'(WIDTH);
            end
         end
         RUN: begin
            a_d   = step_a;
            q_d   = step_q;
            q1_d  = step_q1;
            cnt_d = cnt_q - CNT_W'(1);
            if (last_step) begin
               prod_d = {step_a[WIDTH-1:0], step_q};
            end
         end
         default: ;
      endcase
   end

   assign bus.product = prod_q;

endmodule
